// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_pkg
// Description : Shared definitions for the flag/branch unit: flag bit
//               positions in the {Z,V,N} vector, condition-code constants
//               and the branch FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package flag_pkg;

    // Bit positions inside the 3-bit flag vector {Z,V,N}
    localparam int unsigned c_flag_z = 2;
    localparam int unsigned c_flag_v = 1;
    localparam int unsigned c_flag_n = 0;

    // Condition codes
    localparam logic [2:0] c_cond_ne = 3'b000;  // Z=0
    localparam logic [2:0] c_cond_eq = 3'b001;  // Z=1
    localparam logic [2:0] c_cond_gt = 3'b010;  // Z=0 and N=0
    localparam logic [2:0] c_cond_lt = 3'b011;  // N=1
    localparam logic [2:0] c_cond_ge = 3'b100;  // Z=1 or (Z=0 and N=0)
    localparam logic [2:0] c_cond_le = 3'b101;  // N=1 or Z=1
    localparam logic [2:0] c_cond_vs = 3'b110;  // V=1
    localparam logic [2:0] c_cond_al = 3'b111;  // always

    // FSM state encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_resolve = 2'd1;
    localparam logic [1:0] c_st_flush   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = c_st_idle,
        S_RESOLVE = c_st_resolve,
        S_FLUSH   = c_st_flush
    } state_t;

endpackage : flag_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational branch condition evaluator.
// Ports       : flags [2:0] in  - flag vector {Z,V,N}
//               cond  [2:0] in  - condition code
//               take        out - 1 when the condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       take
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[c_flag_z];
    assign w_v = flags[c_flag_v];
    assign w_n = flags[c_flag_n];

    always_comb begin
        take = 1'b0;
        unique case (cond)
            c_cond_ne: take = ~w_z;
            c_cond_eq: take = w_z;
            c_cond_gt: take = ~w_z & ~w_n;
            c_cond_lt: take = w_n;
            c_cond_ge: take = w_z | (~w_z & ~w_n);
            c_cond_le: take = w_n | w_z;
            c_cond_vs: take = w_v;
            c_cond_al: take = 1'b1;
            default:   take = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Flag register plus a three-state branch resolver.
//               A branch accepted in IDLE is evaluated on forwarded flags;
//               the decision and target are registered, and the following
//               RESOLVE cycle pulses br_done (and redirect if taken). A taken
//               branch spends one extra FLUSH cycle before returning to IDLE.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               flag_in/flag_en/flag_wr - flag write port {Z,V,N}
//               br_valid/br_ready       - branch request handshake
//               br_cond/br_type         - condition code, 0=B 1=BR
//               pc_plus2/br_imm/br_reg  - target operands
//               flags                   - current flag register
//               redirect/next_pc        - taken-branch pulse and target
//               br_done                 - resolved-branch pulse
//               taken_cnt               - saturating taken-branch count
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  flag_in,
    input  logic [2:0]  flag_en,
    input  logic        flag_wr,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic        br_type,
    input  logic [15:0] pc_plus2,
    input  logic [8:0]  br_imm,
    input  logic [15:0] br_reg,
    output logic [2:0]  flags,
    output logic        redirect,
    output logic [15:0] next_pc,
    output logic        br_done,
    output logic [15:0] taken_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flags;
    logic        r_taken;
    logic [15:0] r_next_pc;
    logic [15:0] r_taken_cnt;

    logic [2:0]  w_flag_we;
    logic [2:0]  w_fwd_flags;
    logic        w_accept;
    logic        w_take;
    logic [15:0] w_imm_ext;
    logic [15:0] w_target;

    // Bits written this cycle are forwarded so a branch issued alongside a
    // flag write sees the new value.
    assign w_flag_we   = flag_en & {3{flag_wr}};
    assign w_fwd_flags = (flag_in & w_flag_we) | (r_flags & ~w_flag_we);

    cond_eval u_cond_eval (
        .flags (w_fwd_flags),
        .cond  (br_cond),
        .take  (w_take)
    );

    // Word offset: sign-extend 9 bits and shift left by one (6+9+1 = 16).
    assign w_imm_ext = {{6{br_imm[8]}}, br_imm, 1'b0};
    assign w_target  = br_type ? br_reg : (pc_plus2 + w_imm_ext);

    assign w_accept = br_valid & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flags     <= 3'b000;
            r_taken     <= 1'b0;
            r_next_pc   <= 16'h0000;
            r_taken_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_flags <= w_fwd_flags;
            if (w_accept) begin
                r_taken <= w_take;
                if (w_take) begin
                    r_next_pc <= w_target;
                    if (r_taken_cnt != 16'hFFFF) begin
                        r_taken_cnt <= r_taken_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        br_ready    = 1'b0;
        redirect    = 1'b0;
        br_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                br_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                // Pulses are masked during reset so an in-flight branch
                // never escapes once rst is raised.
                br_done     = ~rst;
                redirect    = r_taken & ~rst;
                w_state_nxt = r_taken ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign flags     = r_flags;
    assign next_pc   = r_next_pc;
    assign taken_cnt = r_taken_cnt;

endmodule : flag_branch_unit
`default_nettype wire

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port flag_in  input  3  ALU flags {Z,V,N} (bit2=Z, bit1=V, bit0=N).
REQ-004 SHALL have port flag_en  input  3  per-bit flag write enables, same bit order as flag_in.
REQ-005 SHALL have port flag_wr  input  1  flag write qualifier; a bit is written only when flag_wr and its flag_en bit are both 1.
REQ-006 SHALL have port br_valid  input  1  branch request present.
REQ-007 SHALL have port br_ready  output  1  unit can accept a branch; equals 1 only in IDLE.
REQ-008 SHALL have port br_cond  input  3  condition code.
REQ-009 SHALL have port br_type  input  1  target select: 0 = PC-relative (B), 1 = register (BR).
REQ-010 SHALL have port pc_plus2  input  16  address of the following instruction.
REQ-011 SHALL have port br_imm  input  9  signed word offset.
REQ-012 SHALL have port br_reg  input  16  register target.
REQ-013 SHALL have port flags  output  3  current flag register {Z,V,N}.
REQ-014 SHALL have port redirect  output  1  one-cycle pulse: taken branch, fetch from next_pc.
REQ-015 SHALL have port next_pc  output  16  registered branch target; valid while redirect=1.
REQ-016 SHALL have port br_done  output  1  one-cycle pulse on every resolved branch, taken or not.
REQ-017 SHALL have port taken_cnt  output  16  count of taken branches.

Function
REQ-018 Flag register SHALL update each enabled bit from flag_in on the clock edge; disabled bits SHALL hold.
REQ-019 Flag writes SHALL be accepted in every FSM state.
REQ-020 Branch SHALL be accepted when br_valid=1 and br_ready=1.
REQ-021 On acceptance, the condition SHALL be evaluated on forwarded flags: each bit takes flag_in if written this cycle, else the register value.
REQ-022 Conditions SHALL be: 000 Z=0; 001 Z=1; 010 Z=0 and N=0; 011 N=1; 100 Z=1 or (Z=0 and N=0); 101 N=1 or Z=1; 110 V=1; 111 always.
REQ-023 B target SHALL be pc_plus2 + (sign_ext(br_imm) << 1), truncated to 16 bits; wraparound is silent.
REQ-024 BR target SHALL be br_reg unchanged.
REQ-025 FSM states SHALL be IDLE, RESOLVE, FLUSH.
REQ-026 IDLE -> RESOLVE on acceptance; otherwise IDLE holds.
REQ-027 In RESOLVE, br_done SHALL be 1 for exactly one cycle.
REQ-028 In RESOLVE, a taken branch SHALL set redirect=1 and next_pc=target, then go to FLUSH.
REQ-029 In RESOLVE, a not-taken branch SHALL leave redirect=0 and return to IDLE.
REQ-030 FLUSH SHALL last one cycle, then go to IDLE; br_valid SHALL be ignored in FLUSH.
REQ-031 Latency SHALL be: acceptance at edge N, redirect/br_done high during cycle N+1.
REQ-032 taken_cnt SHALL increment once per taken branch and saturate at 16'hFFFF.
REQ-033 next_pc SHALL hold its last target when redirect=0.

Reset
REQ-034 While rst=1, the unit SHALL set flags=3'b000, state=IDLE, redirect=0, br_done=0, next_pc=16'h0000, taken_cnt=0.
REQ-035 Reset SHALL override any in-flight RESOLVE or FLUSH; no redirect SHALL be emitted after reset.
REQ-036 Flag writes and branch requests presented during reset SHALL be discarded.
REQ-037 br_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-038 Shared package flag_pkg SHALL hold the flag bit indices (Z=2, V=1, N=0), the eight condition-code constants and the FSM state encoding.
REQ-039 Condition evaluation SHALL be one combinational sub-module, cond_eval (3-bit flags, 3-bit cond in; 1-bit take out).
REQ-040 The flag register, target adder, FSM and counter SHALL live in flag_branch_unit.

Verification
REQ-041 Sequence: flag_wr=1, flag_en=111, flag_in=100; next cycle, cond=001, B, pc_plus2=16'h0010, imm=9'h004 -> redirect one cycle later, next_pc=16'h0018, taken_cnt=1.
REQ-042 Sequence: flags=000; cond=011 -> br_done=1, redirect=0, state back to IDLE next cycle.
REQ-043 In the same cycle: flag_wr with flag_en=010, flag_in=010, plus br_valid with cond=110 -> taken via forwarding, then flags=010.
REQ-044 B with pc_plus2=16'h0002, imm=9'h1FE (-2) -> next_pc=16'hFFFE; BR with br_reg=16'hABCD -> next_pc=16'hABCD.
REQ-045 Hold br_valid high across FLUSH -> not accepted until IDLE; assert rst during RESOLVE -> no redirect, all reset values of REQ-034.
REQ-046 Force taken_cnt to 16'hFFFF, then issue cond=111 -> taken_cnt stays 16'hFFFF.
